keypad_entry_ctrl: RTL and testbench
====================================

Name: keypad_entry_ctrl

Overview:
Controller between Keypad_Top and Display.
- Takes the decoded key code and pressed level from the keypad scanner.
- Turns each key press into an entry action: append digit, backspace, clear or enter.
- Drives the four display digit nibbles and blanking mask.
- On enter, publishes a 4-digit BCD value with a one-cycle done pulse, holds the result on the display, then returns to idle. An inactivity timeout also aborts entry and returns to idle.

Parameters:
HOLD_CYCLES, 25_000_000, cycles the entered value stays displayed after enter (min 1)
TIMEOUT_CYCLES, 250_000_000, idle cycles in ENTRY before auto-clear (min 2)
CNT_W, 28, timer width; must satisfy 2^CNT_W > max(HOLD_CYCLES, TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
key_code  in  4  encoded key from keypad scanner (enc_out[3:0]), valid while key_pressed=1
key_pressed  in  1  key-held level from keypad scanner
digit4  out  4  display digit, most significant
digit3  out  4  display digit
digit2  out  4  display digit
digit1  out  4  display digit, least significant (newest entry)
blank  out  4  per-digit blank mask, bit3=digit4 … bit0=digit1, 1=unused position
digit_count  out  3  digits entered, 0..4
entry_value  out  16  {digit4,digit3,digit2,digit1} BCD captured at enter
entry_done  out  1  one-cycle pulse when entry_value updates
state  out  2  00 IDLE, 01 ENTRY, 10 HOLD

Behaviour:
- Reset (rst=0, async): all digits 0, blank=4'b1111, digit_count=0, entry_value=0, entry_done=0, state=IDLE, timer=0, edge register=0.
- Key event: key_pressed is registered. An event is asserted the cycle after a 0→1 transition; key_code is sampled on the same edge as the rising transition.
  - Holding a key produces exactly one event. A new event requires a release first.
  - Action takes effect on outputs one clk after the event (2 cycles after key_pressed rises).
- Key map:
  - 0x0–0x9 = digit
  - 0xA = backspace
  - 0xB = clear
  - 0xC = enter
  - 0xD–0xF = ignored (no state or timer change)
- IDLE:
  - Digit key → shift in (digit1=key, count=1), blank=4'b1110, go ENTRY, timer=0.
  - Other keys: no effect.
- ENTRY:
  - Digit with count<4 → {d4,d3,d2,d1} ← {d3,d2,d1,key}, count+1, blank shifts left with 0 in.
  - Digit with count=4 → ignored, but timer still resets.
  - Backspace → {d4,d3,d2,d1} ← {0,d4,d3,d2}, count-1, blank ← {1,blank[3:1]}. If count reaches 0 → IDLE.
  - Clear → all digits 0, blank=1111, count=0, IDLE.
  - Enter with count≥1 → entry_value ← current digits (unused positions read 0), entry_done=1 for exactly one cycle, go HOLD, timer=0.
  - Enter with count=0 cannot occur (count=0 implies IDLE).
  - Any accepted key (0x0–0xC) clears the timer. Otherwise timer increments each cycle.
  - timer=TIMEOUT_CYCLES-1 with no event that cycle → clear as for key 0xB, go IDLE, no entry_done.
  - Key event in the same cycle as expiry: the key wins and the timer resets.
- HOLD:
  - Digits and blank frozen, all key events ignored, timer increments.
  - At timer=HOLD_CYCLES-1 → clear digits, blank=1111, count=0, IDLE.
  - A key still held on entry to IDLE produces no event until it is released and pressed again.
- entry_value holds its value until the next enter or reset.
- Timer saturates; it never wraps in any state.

Decomposition:
- Package keypad_pkg holds:
  - key code constants: KEY_BS=4'hA, KEY_CLR=4'hB, KEY_ENT=4'hC
  - state encoding: ST_IDLE, ST_ENTRY, ST_HOLD
  - helper function is_digit(code)
- One sub-module, key_event_detect: registers key_pressed, emits the 1-cycle event plus the latched code; async active-low reset.
- keypad_entry_ctrl contains the FSM, digit shift register and timer.

Test Plan:
All tests use HOLD_CYCLES=4 and TIMEOUT_CYCLES=20.
1. Press 1,2,3 (each held 3 cycles, released 2) → digits 0,1,2,3; blank=1000; count=3; state=ENTRY.
2. Press 1,2,3,4,5 → digits 1,2,3,4; fifth ignored; count=4; blank=0000.
3. Enter 7,8, backspace, 9, then C → entry_value=16'h0079; entry_done high 1 cycle; state=HOLD for 4 cycles. Keys pressed in HOLD are ignored; then IDLE with blank=1111 and entry_value still 0079.
4. Enter 5, idle 20 cycles → state returns to IDLE, digits cleared, no entry_done. Repeat with a key arriving exactly at cycle 20 → key accepted and timer restarted.
5. Hold key 6 pressed for 50 cycles → exactly one digit entered. Keys 0xD/0xE in ENTRY → no change.
6. Assert rst low mid-ENTRY, between clock edges → all outputs go to reset values immediately, asynchronously. Release rst, press 4 → digit1=4, count=1.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the keypad entry controller.
//   - Key codes for the non-digit actions (backspace, clear, enter).
//   - State encoding of the entry FSM. The same values appear on the
//     controller's state output.
//   - Helper functions that classify a decoded key code.
package keypad_pkg;

  localparam logic [3:0] KEY_BS  = 4'hA;
  localparam logic [3:0] KEY_CLR = 4'hB;
  localparam logic [3:0] KEY_ENT = 4'hC;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ENTRY = 2'b01;
  localparam logic [1:0] ST_HOLD  = 2'b10;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

  // Codes 0x0..0xC map to an action. 0xD..0xF are treated as if no key
  // had been pressed.
  function automatic logic is_action(input logic [3:0] code);
    return (code <= KEY_ENT);
  endfunction

endpackage

// File: rtl/key_event_detect.sv
// key_event_detect: turns the keypad scanner's key-held level into a
// single-cycle event.
//   clk         : system clock, rising edge
//   rst         : asynchronous reset, active-low
//   key_pressed : key-held level from the scanner
//   key_code    : decoded key, valid while key_pressed=1
//   key_event   : high for one cycle, the cycle after the 0->1 transition
//   event_code  : key_code captured on the edge that saw the transition
// A held key yields exactly one event. The level has to drop and rise
// again before the next event is produced.
module key_event_detect
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       key_pressed,
  input  logic [3:0] key_code,
  output logic       key_event,
  output logic [3:0] event_code
);

  logic pressed_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pressed_q  <= 1'b0;
      key_event  <= 1'b0;
      event_code <= 4'h0;
    end else begin
      pressed_q <= key_pressed;
      key_event <= key_pressed & ~pressed_q;
      if (key_pressed && !pressed_q) begin
        event_code <= key_code;
      end
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: converts keypad events into a 4-digit BCD entry that
// is shown on a display.
//   clk         : system clock, rising edge
//   rst         : asynchronous reset, active-low
//   key_code    : decoded key from the scanner
//   key_pressed : key-held level from the scanner
//   digit4..1   : display nibbles. digit1 holds the newest entry.
//   blank       : per-digit blank mask (bit3=digit4). A 1 marks an unused position.
//   digit_count : number of digits entered, 0..4
//   entry_value : BCD value captured on enter. It is held until the next enter.
//   entry_done  : one-cycle pulse when entry_value updates
//   state       : FSM state (00 IDLE, 01 ENTRY, 10 HOLD)
// Handshake: there is no backpressure. key_event is a one-cycle strobe
// that qualifies event_code, and entry_done is a one-cycle strobe that
// qualifies entry_value.
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES    = 25_000_000,
  parameter int TIMEOUT_CYCLES = 250_000_000,
  parameter int CNT_W          = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  key_code,
  input  logic        key_pressed,
  output logic [3:0]  digit4,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic [3:0]  blank,
  output logic [2:0]  digit_count,
  output logic [15:0] entry_value,
  output logic        entry_done,
  output logic [1:0]  state
);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_MAX    = '1;

  logic       key_event;
  logic [3:0] event_code;

  key_event_detect u_key_event_detect (
    .clk        (clk),
    .rst        (rst),
    .key_pressed(key_pressed),
    .key_code   (key_code),
    .key_event  (key_event),
    .event_code (event_code)
  );

  logic [15:0]      digits, digits_n;
  logic [3:0]       blank_n;
  logic [2:0]       count_n;
  logic [1:0]       state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [15:0]      value_n;
  logic             done_n;
  logic             act;

  // Only codes 0x0..0xC count as events. Ignored codes leave the timer running.
  assign act = key_event & is_action(event_code);

  always_comb begin
    digits_n = digits;
    blank_n  = blank;
    count_n  = digit_count;
    state_n  = state;
    timer_n  = (timer == TIMER_MAX) ? timer : timer + 1'b1;
    value_n  = entry_value;
    done_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        timer_n = '0;
        if (act && is_digit(event_code)) begin
          digits_n = {12'h000, event_code};
          blank_n  = 4'b1110;
          count_n  = 3'd1;
          state_n  = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        // A key event wins over a timeout that expires in the same cycle.
        if (act) begin
          timer_n = '0;
          if (is_digit(event_code)) begin
            if (digit_count < 3'd4) begin
              digits_n = {digits[11:0], event_code};
              blank_n  = {blank[2:0], 1'b0};
              count_n  = digit_count + 3'd1;
            end
          end else if (event_code == KEY_BS) begin
            digits_n = {4'h0, digits[15:4]};
            blank_n  = {1'b1, blank[3:1]};
            count_n  = digit_count - 3'd1;
            if (digit_count == 3'd1) begin
              state_n = ST_IDLE;
            end
          end else if (event_code == KEY_CLR) begin
            digits_n = 16'h0000;
            blank_n  = 4'b1111;
            count_n  = 3'd0;
            state_n  = ST_IDLE;
          end else begin
            // Enter. Unused positions already hold 0 because shifts bring in zeros.
            value_n = digits;
            done_n  = 1'b1;
            state_n = ST_HOLD;
          end
        end else if (timer == TIMEOUT_LAST) begin
          digits_n = 16'h0000;
          blank_n  = 4'b1111;
          count_n  = 3'd0;
          state_n  = ST_IDLE;
          timer_n  = '0;
        end
      end
      ST_HOLD: begin
        if (timer == HOLD_LAST) begin
          digits_n = 16'h0000;
          blank_n  = 4'b1111;
          count_n  = 3'd0;
          state_n  = ST_IDLE;
          timer_n  = '0;
        end
      end
      default: begin
        digits_n = 16'h0000;
        blank_n  = 4'b1111;
        count_n  = 3'd0;
        state_n  = ST_IDLE;
        timer_n  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digits      <= 16'h0000;
      blank       <= 4'b1111;
      digit_count <= 3'd0;
      state       <= ST_IDLE;
      timer       <= '0;
      entry_value <= 16'h0000;
      entry_done  <= 1'b0;
    end else begin
      digits      <= digits_n;
      blank       <= blank_n;
      digit_count <= count_n;
      state       <= state_n;
      timer       <= timer_n;
      entry_value <= value_n;
      entry_done  <= done_n;
    end
  end

  assign digit4 = digits[15:12];
  assign digit3 = digits[11:8];
  assign digit2 = digits[7:4];
  assign digit1 = digits[3:0];

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: directed bench for keypad_entry_ctrl with
// HOLD_CYCLES=4 and TIMEOUT_CYCLES=20. Inputs are driven on falling edges
// and outputs are sampled on falling edges.
module tb_keypad_entry_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  key_code;
  logic        key_pressed;
  logic [3:0]  digit4, digit3, digit2, digit1;
  logic [3:0]  blank;
  logic [2:0]  digit_count;
  logic [15:0] entry_value;
  logic        entry_done;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  keypad_entry_ctrl #(
    .HOLD_CYCLES   (4),
    .TIMEOUT_CYCLES(20),
    .CNT_W         (28)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_code   (key_code),
    .key_pressed(key_pressed),
    .digit4     (digit4),
    .digit3     (digit3),
    .digit2     (digit2),
    .digit1     (digit1),
    .blank      (blank),
    .digit_count(digit_count),
    .entry_value(entry_value),
    .entry_done (entry_done),
    .state      (state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    key_pressed = 1'b0;
    key_code = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic press_key(input logic [3:0] code, input int hold, input int rel);
    @(negedge clk);
    key_code = code;
    key_pressed = 1'b1;
    repeat (hold) @(negedge clk);
    key_pressed = 1'b0;
    repeat (rel) @(negedge clk);
  endtask

  // Tests.
  task automatic test_reset();
    do_reset();
    checks++; if ({digit4, digit3, digit2, digit1} !== 16'h0000) begin errors++; $display("FAIL reset_digits got %h exp 0000", {digit4, digit3, digit2, digit1}); end
    checks++; if (blank !== 4'b1111) begin errors++; $display("FAIL reset_blank got %b exp 1111", blank); end
    checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", digit_count); end
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", state); end
    checks++; if (entry_done !== 1'b0 || entry_value !== 16'h0000) begin errors++; $display("FAIL reset_entry got done=%b val=%h exp 0/0000", entry_done, entry_value); end
  endtask

  task automatic test_three_digits();
    do_reset();
    press_key(4'h1, 3, 2);
    press_key(4'h2, 3, 2);
    press_key(4'h3, 3, 2);
    checks++; if ({digit4, digit3, digit2, digit1} !== 16'h0123) begin errors++; $display("FAIL three_digits got %h exp 0123", {digit4, digit3, digit2, digit1}); end
    checks++; if (blank !== 4'b1000) begin errors++; $display("FAIL three_blank got %b exp 1000", blank); end
    checks++; if (digit_count !== 3'd3) begin errors++; $display("FAIL three_count got %0d exp 3", digit_count); end
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL three_state got %b exp 01", state); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 5; k++) press_key(4'(k), 3, 2);
    checks++; if ({digit4, digit3, digit2, digit1} !== 16'h1234) begin errors++; $display("FAIL overflow_digits got %h exp 1234", {digit4, digit3, digit2, digit1}); end
    checks++; if (digit_count !== 3'd4) begin errors++; $display("FAIL overflow_count got %0d exp 4", digit_count); end
    checks++; if (blank !== 4'b0000) begin errors++; $display("FAIL overflow_blank got %b exp 0000", blank); end
  endtask

  task automatic test_enter_hold();
    do_reset();
    press_key(4'h7, 3, 2);
    press_key(4'h8, 3, 2);
    press_key(4'hA, 3, 2);
    checks++; if (digit1 !== 4'h7 || digit_count !== 3'd1 || blank !== 4'b1110) begin errors++; $display("FAIL backspace got d1=%h cnt=%0d blank=%b exp 7/1/1110", digit1, digit_count, blank); end
    press_key(4'h9, 3, 2);
    // Enter: the event forms on the first edge and the action happens on the second.
    @(negedge clk);
    key_code = 4'hC;
    key_pressed = 1'b1;
    @(negedge clk);
    checks++; if (entry_done !== 1'b0 || state !== 2'b01) begin errors++; $display("FAIL enter_early got done=%b state=%b exp 0/01", entry_done, state); end
    @(negedge clk);
    key_pressed = 1'b0;
    checks++; if (entry_done !== 1'b1) begin errors++; $display("FAIL enter_done got %b exp 1", entry_done); end
    checks++; if (entry_value !== 16'h0079) begin errors++; $display("FAIL enter_value got %h exp 0079", entry_value); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL enter_state got %b exp 10", state); end
    @(negedge clk);
    checks++; if (entry_done !== 1'b0 || state !== 2'b10) begin errors++; $display("FAIL hold1 got done=%b state=%b exp 0/10", entry_done, state); end
    key_code = 4'h5;
    key_pressed = 1'b1;
    @(negedge clk);
    key_pressed = 1'b0;
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL hold2 got state=%b exp 10", state); end
    @(negedge clk);
    checks++; if (state !== 2'b10 || {digit2, digit1} !== 8'h79) begin errors++; $display("FAIL hold3 got state=%b d=%h exp 10/79", state, {digit2, digit1}); end
    @(negedge clk);
    checks++; if (state !== 2'b00 || blank !== 4'b1111 || digit_count !== 3'd0) begin errors++; $display("FAIL hold_exit got state=%b blank=%b cnt=%0d exp 00/1111/0", state, blank, digit_count); end
    checks++; if (entry_value !== 16'h0079 || {digit2, digit1} !== 8'h00) begin errors++; $display("FAIL hold_exit_value got val=%h d=%h exp 0079/00", entry_value, {digit2, digit1}); end
  endtask

  task automatic test_timeout();
    logic saw_done;
    do_reset();
    saw_done = 1'b0;
    @(negedge clk);
    key_code = 4'h5;
    key_pressed = 1'b1;
    @(negedge clk);
    key_pressed = 1'b0;
    @(negedge clk);
    checks++; if (state !== 2'b01 || digit1 !== 4'h5) begin errors++; $display("FAIL timeout_start got state=%b d1=%h exp 01/5", state, digit1); end
    repeat (19) begin
      @(negedge clk);
      saw_done = saw_done | entry_done;
    end
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL timeout_before got state=%b exp 01", state); end
    @(negedge clk);
    saw_done = saw_done | entry_done;
    checks++; if (state !== 2'b00 || digit1 !== 4'h0 || blank !== 4'b1111) begin errors++; $display("FAIL timeout_expire got state=%b d1=%h blank=%b exp 00/0/1111", state, digit1, blank); end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL timeout_no_done got %b exp 0", saw_done); end
    // A second entry with a key event landing on the expiry cycle.
    @(negedge clk);
    key_code = 4'h5;
    key_pressed = 1'b1;
    @(negedge clk);
    key_pressed = 1'b0;
    @(negedge clk);
    repeat (18) @(negedge clk);
    key_code = 4'h6;
    key_pressed = 1'b1;
    @(negedge clk);
    key_pressed = 1'b0;
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL race_pre got state=%b exp 01", state); end
    @(negedge clk);
    checks++; if (state !== 2'b01 || {digit2, digit1} !== 8'h56 || digit_count !== 3'd2) begin errors++; $display("FAIL race_key_wins got state=%b d=%h cnt=%0d exp 01/56/2", state, {digit2, digit1}, digit_count); end
    repeat (19) @(negedge clk);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL race_restart got state=%b exp 01", state); end
    @(negedge clk);
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL race_expire got state=%b exp 00", state); end
  endtask

  task automatic test_held_and_ignored();
    do_reset();
    @(negedge clk);
    key_code = 4'h6;
    key_pressed = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (digit_count !== 3'd1 || digit1 !== 4'h6) begin errors++; $display("FAIL held_one got cnt=%0d d1=%h exp 1/6", digit_count, digit1); end
    // The key stays down past the timeout, and re-entering IDLE must not retrigger.
    repeat (40) @(negedge clk);
    checks++; if (state !== 2'b00 || digit_count !== 3'd0) begin errors++; $display("FAIL held_no_retrigger got state=%b cnt=%0d exp 00/0", state, digit_count); end
    key_pressed = 1'b0;
    @(negedge clk);
    press_key(4'h3, 3, 2);
    press_key(4'hD, 3, 2);
    press_key(4'hE, 3, 2);
    checks++; if (state !== 2'b01 || digit_count !== 3'd1 || digit1 !== 4'h3 || blank !== 4'b1110) begin errors++; $display("FAIL ignored_keys got state=%b cnt=%0d d1=%h blank=%b exp 01/1/3/1110", state, digit_count, digit1, blank); end
  endtask

  task automatic test_async_reset();
    do_reset();
    press_key(4'h2, 3, 2);
    press_key(4'hC, 3, 2);
    repeat (6) @(negedge clk);
    press_key(4'h2, 3, 2);
    press_key(4'h3, 3, 2);
    checks++; if (state !== 2'b01 || entry_value !== 16'h0002) begin errors++; $display("FAIL pre_reset got state=%b val=%h exp 01/0002", state, entry_value); end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++; if ({digit4, digit3, digit2, digit1} !== 16'h0000 || blank !== 4'b1111 || digit_count !== 3'd0) begin errors++; $display("FAIL async_digits got d=%h blank=%b cnt=%0d exp 0000/1111/0", {digit4, digit3, digit2, digit1}, blank, digit_count); end
    checks++; if (state !== 2'b00 || entry_value !== 16'h0000 || entry_done !== 1'b0) begin errors++; $display("FAIL async_state got state=%b val=%h done=%b exp 00/0000/0", state, entry_value, entry_done); end
    @(negedge clk);
    rst = 1'b1;
    press_key(4'h4, 3, 2);
    checks++; if (digit1 !== 4'h4 || digit_count !== 3'd1 || state !== 2'b01) begin errors++; $display("FAIL after_reset got d1=%h cnt=%0d state=%b exp 4/1/01", digit1, digit_count, state); end
  endtask

  initial begin
    rst = 1'b0;
    key_pressed = 1'b0;
    key_code = 4'h0;
    test_reset();
    test_three_digits();
    test_overflow();
    test_enter_hold();
    test_timeout();
    test_held_and_ignored();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
